prog_seq: RTL
=============

PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter ADDR_W, default 10: program counter / load address width in bits.
REQ-002 Parameter CNT_W, default 16: cycle counter width in bits.
REQ-003 Parameter MAX_CYCLES, default 16'd4095: run-length limit in cycles before forced termination.
REQ-004 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Reset  input  1  reset, synchronous and active-high.
REQ-006 Start  input  1  request to launch a program; level-sampled.
REQ-007 ProgSel  input  2  program index; sampled on the first cycle Start=1 seen in IDLE.
REQ-008 Done  input  1  halt instruction decoded by the datapath this cycle.
REQ-009 Stall  input  1  datapath not ready; freezes PC advance.
REQ-010 LoadEn  output  1  load LoadAddr into the program counter this cycle.
REQ-011 LoadAddr  output  ADDR_W  program base address.
REQ-012 PcEn  output  1  program counter may advance or branch this cycle.
REQ-013 Busy  output  1  high in any state other than IDLE.
REQ-014 Ack  output  1  one-cycle completion pulse.
REQ-015 Timeout  output  1  last run hit MAX_CYCLES; sticky until next launch.
REQ-016 BadSel  output  1  last launch used an invalid ProgSel; sticky until next launch.
REQ-017 CycleCount  output  CNT_W  cycles spent in RUN in the current or last run.

Function
REQ-018 FSM states SHALL be IDLE, ARMED, LOAD, RUN, FIN; exactly one state is active per cycle.
REQ-019 IDLE: Start=1 -> ARMED; ProgSel latched into SelReg on the same edge.
REQ-020 ARMED: stay while Start=1; Start=0 -> LOAD if SelReg<3, else FIN with BadSel set.
REQ-021 LOAD: LoadEn=1 for exactly one cycle; LoadAddr=PROG_BASE[SelReg]; CycleCount cleared; Timeout and BadSel cleared; next state RUN.
REQ-022 LoadAddr SHALL be 0 whenever LoadEn=0.
REQ-023 RUN: PcEn = ~Stall; PcEn=0 in all other states.
REQ-024 RUN: CycleCount increments by 1 every RUN cycle, stalled or not.
REQ-025 RUN: Done=1 -> FIN in the same cycle, regardless of Stall; Done has priority over timeout.
REQ-026 RUN: Done=0 with CycleCount==MAX_CYCLES-1 -> FIN with Timeout=1; the count reaches MAX_CYCLES on that edge and never exceeds it.
REQ-027 FIN: Ack=1 for one cycle, then -> IDLE; Ack=0 in all other states.
REQ-028 Start SHALL be ignored in LOAD, RUN and FIN; a relaunch requires Start to be sampled in IDLE.
REQ-029 Done and Stall SHALL be ignored outside RUN.
REQ-030 CycleCount, Timeout and BadSel SHALL hold their values in FIN and IDLE until the next LOAD (or, for BadSel, the next ARMED exit).
REQ-031 Launch latency: Start falling edge sampled in ARMED -> LoadEn on the next cycle -> first PcEn one cycle later.

Reset
REQ-032 Reset=1 on a rising edge forces IDLE, SelReg=0, CycleCount=0, Timeout=0 and BadSel=0 from any state, including mid-RUN.
REQ-033 During and after reset: LoadEn=0, LoadAddr=0, PcEn=0, Busy=0, Ack=0.
REQ-034 Reset SHALL have priority over every other input in the same cycle.

Structure
REQ-035 Package prog_seq_pkg SHALL hold the state enum, the PROG_BASE array ({10'd0, 10'd128, 10'd256}), and the MAX_CYCLES default.
REQ-036 The cycle counter with clear, enable and limit compare SHALL be the sub-module prog_seq_cnt; the FSM and output decode stay in prog_seq.
REQ-037 All outputs SHALL decode from registered state only, so there is no combinational path from Start to any output.

Verification
REQ-038 Reset mid-RUN with CycleCount=7 -> next cycle IDLE, CycleCount=0, PcEn=0, Busy=0.
REQ-039 ProgSel=1, Start high for 2 cycles, then low -> one LoadEn cycle with LoadAddr=128; PcEn=1 on the following cycle.
REQ-040 In RUN, Stall=1 for 3 cycles, then Done after 5 total RUN cycles -> PcEn=0 on the stalled cycles, CycleCount=5, one Ack pulse, then IDLE.
REQ-041 MAX_CYCLES=8, Done never asserted -> Timeout=1, CycleCount=8, Ack after the 8th RUN cycle.
REQ-042 ProgSel=3, Start pulse -> no LoadEn, BadSel=1, Ack pulse; the next valid launch clears BadSel.
REQ-043 Start held high throughout RUN and Done asserted on the same cycle as Stall -> FIN taken, no relaunch until Start is sampled in IDLE.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program sequencer: the state encoding, the
// table of program base addresses and the default run-length limit.
`timescale 1ns/1ps

package prog_seq_pkg;

    // Sequencer states, one active per cycle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Width of the entries in the base address table.
    localparam int BASE_W = 10;

    // Number of valid programs; any ProgSel at or above this is rejected.
    localparam logic [1:0] NUM_PROGS = 2'd3;

    // Start address of each program in instruction memory.
    localparam logic [BASE_W-1:0] PROG_BASE [3] = '{10'd0, 10'd128, 10'd256};

    // Default number of RUN cycles before a program is forcibly ended.
    localparam logic [15:0] MAX_CYCLES_DEFAULT = 16'd4095;

    // Looks up a base address. Out-of-range selections return 0, although the
    // sequencer never loads one.
    function automatic logic [BASE_W-1:0] progBase(input logic [1:0] sel);
        logic [BASE_W-1:0] addr;
        case (sel)
            2'd0:    addr = PROG_BASE[0];
            2'd1:    addr = PROG_BASE[1];
            2'd2:    addr = PROG_BASE[2];
            default: addr = '0;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/prog_seq_cnt.sv
// RUN-cycle counter for the program sequencer. It clears at the start of a
// launch, counts while enabled, and flags the last cycle before the limit.
`timescale 1ns/1ps

module prog_seq_cnt
    import prog_seq_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'(MAX_CYCLES_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_lastCycle
);

    localparam logic [CNT_W-1:0] LAST_VALUE = MAX_CYCLES - CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // The count saturates at MAX_CYCLES. The sequencer always leaves RUN when
    // the limit is reached, so it never needs to count further.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX_CYCLES)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count     = r_count;
    assign o_lastCycle = (r_count == LAST_VALUE);

endmodule

// File: rtl/prog_seq.sv
// Program sequencer. It launches one of a few fixed programs, lets the
// datapath run until it halts or until a cycle limit is hit, and then reports
// completion. All outputs decode from registered state. Stall reaches the
// outputs only through PcEn while in RUN.
`timescale 1ns/1ps

module prog_seq
    import prog_seq_pkg::*;
#(
    parameter int               ADDR_W     = 10,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'(MAX_CYCLES_DEFAULT)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_progSel,
    input  logic              i_done,
    input  logic              i_stall,
    output logic              o_loadEn,
    output logic [ADDR_W-1:0] o_loadAddr,
    output logic              o_pcEn,
    output logic              o_busy,
    output logic              o_ack,
    output logic              o_timeout,
    output logic              o_badSel,
    output logic [CNT_W-1:0]  o_cycleCount
);

    state_t           r_state;
    state_t           w_nextState;
    logic [1:0]       r_selReg;
    logic             r_timeout;
    logic             r_badSel;
    logic             w_setTimeout;
    logic             w_setBadSel;
    logic             w_launch;
    logic             w_running;
    logic             w_lastCycle;
    logic [CNT_W-1:0] w_count;

    // A LOAD cycle starts a fresh run. The counter and both status flags are
    // wiped on the edge that leaves LOAD.
    assign w_launch  = (r_state == LOAD);
    assign w_running = (r_state == RUN);

    prog_seq_cnt #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cnt (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_launch),
        .i_enable    (w_running),
        .o_count     (w_count),
        .o_lastCycle (w_lastCycle)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture the program index on the same edge that leaves IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_selReg <= 2'd0;
        end else if ((r_state == IDLE) && i_start) begin
            r_selReg <= i_progSel;
        end
    end

    // Status flags stay set until the next launch so that software can read
    // them after the run has finished.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_timeout <= 1'b0;
            r_badSel  <= 1'b0;
        end else if (w_launch) begin
            r_timeout <= 1'b0;
            r_badSel  <= 1'b0;
        end else begin
            if (w_setTimeout) begin
                r_timeout <= 1'b1;
            end
            if (w_setBadSel) begin
                r_badSel <= 1'b1;
            end
        end
    end

    // Next-state logic. Done has priority over the cycle limit. Start is
    // looked at only in IDLE and ARMED, so holding it through a run cannot
    // cause a relaunch.
    always_comb begin
        w_nextState  = r_state;
        w_setTimeout = 1'b0;
        w_setBadSel  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = ARMED;
                end
            end
            ARMED: begin
                if (!i_start) begin
                    if (r_selReg < NUM_PROGS) begin
                        w_nextState = LOAD;
                    end else begin
                        w_nextState = FIN;
                        w_setBadSel = 1'b1;
                    end
                end
            end
            LOAD: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (i_done) begin
                    w_nextState = FIN;
                end else if (w_lastCycle) begin
                    w_nextState  = FIN;
                    w_setTimeout = 1'b1;
                end
            end
            FIN: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output decode from the current state. LoadAddr is forced to zero
    // outside LOAD so the datapath never sees a stale address.
    always_comb begin
        o_loadEn   = 1'b0;
        o_loadAddr = '0;
        o_pcEn     = 1'b0;
        o_ack      = 1'b0;
        o_busy     = (r_state != IDLE);
        case (r_state)
            LOAD: begin
                o_loadEn   = 1'b1;
                o_loadAddr = ADDR_W'(progBase(r_selReg));
            end
            RUN: begin
                o_pcEn = ~i_stall;
            end
            FIN: begin
                o_ack = 1'b1;
            end
            default: begin
                o_loadEn = 1'b0;
            end
        endcase
    end

    assign o_timeout    = r_timeout;
    assign o_badSel     = r_badSel;
    assign o_cycleCount = w_count;

endmodule
